// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared sizes and load-state encoding for the JAM engine
package jam_pkg;

  localparam int N_SIDE  = 8;
  localparam int COST_W  = 7;
  localparam int IDX_W   = 3;
  localparam int SUM_W   = 10;
  localparam int ADDR_W  = 2 * IDX_W;
  localparam int N_ENTRY = N_SIDE * N_SIDE;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } cost_state_e;

endpackage

// File: rtl/jam_cost_rf.sv
// rtl/jam_cost_rf.sv - cost register file, one write port, one async read port
module jam_cost_rf #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read of the entry being written this cycle sees the pre-edge value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - streamed 8x8 cost matrix store with row-minimum lower bound
module jam_cost_table #(
  parameter int N_SIDE = jam_pkg::N_SIDE,
  parameter int COST_W = jam_pkg::COST_W
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [COST_W-1:0]         InCost,
  input  logic                      Reload,
  input  logic [jam_pkg::IDX_W-1:0] W,
  input  logic [jam_pkg::IDX_W-1:0] J,
  output logic [COST_W-1:0]         Cost,
  output logic                      TableReady,
  output logic [jam_pkg::SUM_W-1:0] LowerBound
);

  import jam_pkg::*;

  localparam int N_CELLS = N_SIDE * N_SIDE;

  cost_state_e       state;
  logic [ADDR_W-1:0] idx;
  logic [COST_W-1:0] row_min;
  logic [COST_W-1:0] row_min_nxt;
  logic [SUM_W-1:0]  lb_acc;
  logic              table_ready;
  logic              accept;
  logic              row_first;
  logic              row_last;

  assign InReady   = (state == LOAD) && !Reload;
  assign accept    = InValid && InReady;
  assign row_first = (idx[IDX_W-1:0] == '0);
  assign row_last  = (idx[IDX_W-1:0] == {IDX_W{1'b1}});

  always_comb begin
    row_min_nxt = InCost;
    if (!row_first && (row_min < InCost)) begin
      row_min_nxt = row_min;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= LOAD;
      idx         <= '0;
      row_min     <= '0;
      lb_acc      <= '0;
      table_ready <= 1'b0;
    end else if (Reload) begin
      state       <= LOAD;
      idx         <= '0;
      row_min     <= '0;
      lb_acc      <= '0;
      table_ready <= 1'b0;
    end else if (accept) begin
      idx     <= idx + 1'b1;
      row_min <= row_min_nxt;
      if (row_last) begin
        lb_acc <= lb_acc + SUM_W'(row_min_nxt);
      end
      // idx wraps to 0 naturally on the final beat.
      if (idx == ADDR_W'(N_CELLS - 1)) begin
        state       <= DONE;
        table_ready <= 1'b1;
      end
    end
  end

  jam_cost_rf #(
    .DEPTH  (N_CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (COST_W)
  ) u_rf (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (accept),
    .waddr (idx),
    .wdata (InCost),
    .raddr ({W, J}),
    .rdata (Cost)
  );

  assign TableReady = table_ready;
  assign LowerBound = lb_acc;

endmodule

// File: tb/tb_jam_cost_table.sv
// tb/tb_jam_cost_table.sv - scoreboard bench for jam_cost_table against a matrix model
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [6:0] InCost = '0;
  logic       Reload = 1'b0;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic [6:0] Cost;
  logic       TableReady;
  logic [9:0] LowerBound;

  int   n_checks = 0;
  int   n_fail = 0;
  int   ref_mem [64];
  int   cost_q [$];
  int   lb_q [$];
  logic rd_strobe = 1'b0;
  logic tr_prev = 1'b0;

  jam_cost_table dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .InValid    (InValid),
    .InReady    (InReady),
    .InCost     (InCost),
    .Reload     (Reload),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .TableReady (TableReady),
    .LowerBound (LowerBound)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Lower bound straight from the matrix: sum over rows of each row's smallest cost.
  function automatic int model_lb();
    int sum = 0;
    for (int r = 0; r < 8; r++) begin
      int m = 1000;
      for (int c = 0; c < 8; c++) begin
        if (ref_mem[r*8+c] < m) m = ref_mem[r*8+c];
      end
      sum += m;
    end
    return sum;
  endfunction

  always @(negedge CLK) begin
    if (rd_strobe) begin
      if (cost_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cost_q_underflow: lookup with no expected entry");
      end else begin
        chk($sformatf("cost[%0d][%0d]", W, J), int'(Cost), cost_q.pop_front());
      end
    end
    if (TableReady && !tr_prev) begin
      if (lb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tableready_rise: LowerBound %0d", LowerBound);
      end else begin
        chk("lower_bound", int'(LowerBound), lb_q.pop_front());
      end
    end
    tr_prev <= TableReady;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) ref_mem[i] = 0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle per beat, 2 random 0..2 idle cycles.
  task automatic load(input int data[64], input int gap_mode, input int nbeats);
    int tr_bad = 0;
    int ir_bad = 0;
    for (int k = 0; k < nbeats; k++) begin
      InValid = 1'b1;
      InCost  = data[k][6:0];
      @(negedge CLK);
      if (TableReady !== 1'b0) tr_bad++;
      if (InReady !== 1'b1) ir_bad++;
      step();
      ref_mem[k] = data[k];
      if (k < nbeats - 1) begin
        int idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        InValid = 1'b0;
        InCost  = 7'($urandom_range(0, 127));
        for (int g = 0; g < idle; g++) begin
          @(negedge CLK);
          if (TableReady !== 1'b0) tr_bad++;
          if (InReady !== 1'b1) ir_bad++;
          step();
        end
      end
    end
    InValid = 1'b0;
    chk("tableready_low_during_load", tr_bad, 0);
    chk("inready_high_during_load", ir_bad, 0);
    if (nbeats == 64) begin
      lb_q.push_back(model_lb());
      @(negedge CLK);
      chk("tableready_after_last_beat", int'(TableReady), 1);
      chk("inready_low_in_done", int'(InReady), 0);
      step();
    end
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) begin
      W = 3'(a >> 3);
      J = 3'(a & 7);
      rd_strobe = 1'b1;
      cost_q.push_back(ref_mem[a]);
      step();
    end
    rd_strobe = 1'b0;
  endtask

  task automatic reload_pulse();
    Reload = 1'b1;
    @(negedge CLK);
    chk("inready_low_during_reload", int'(InReady), 0);
    step();
    Reload = 1'b0;
    @(negedge CLK);
    chk("tableready_low_after_reload", int'(TableReady), 0);
    chk("lower_bound_cleared_by_reload", int'(LowerBound), 0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d [64];
    int ir_bad;
    int tr_bad;

    clear_model();
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("reset_inready", int'(InReady), 1);
    chk("reset_tableready", int'(TableReady), 0);
    chk("reset_lower_bound", int'(LowerBound), 0);
    chk("reset_cost", int'(Cost), 0);
    step();
    RST_N = 1'b1;
    step();
    sweep();

    for (int k = 0; k < 64; k++) d[k] = k % 128;
    load(d, 0, 64);
    sweep();

    reload_pulse();
    load(d, 1, 64);
    sweep();

    reload_pulse();
    for (int k = 0; k < 64; k++) d[k] = (k / 8 == k % 8) ? 1 : 127;
    load(d, 0, 64);
    sweep();

    // Reload collides with a valid beat 30: that beat must be dropped.
    reload_pulse();
    for (int k = 0; k < 64; k++) d[k] = int'($urandom_range(0, 127));
    load(d, 0, 30);
    InValid = 1'b1;
    InCost  = 7'd99;
    Reload  = 1'b1;
    @(negedge CLK);
    chk("inready_low_reload_with_valid", int'(InReady), 0);
    step();
    Reload  = 1'b0;
    InValid = 1'b0;
    for (int k = 0; k < 64; k++) d[k] = 5;
    load(d, 0, 64);
    sweep();

    ir_bad = 0;
    tr_bad = 0;
    InValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      InCost = 7'($urandom_range(0, 127));
      @(negedge CLK);
      if (InReady !== 1'b0) ir_bad++;
      if (TableReady !== 1'b1) tr_bad++;
      step();
    end
    InValid = 1'b0;
    chk("done_hold_inready_low", ir_bad, 0);
    chk("done_hold_tableready_high", tr_bad, 0);
    sweep();

    for (int r = 0; r < 2; r++) begin
      reload_pulse();
      for (int k = 0; k < 64; k++) d[k] = int'($urandom_range(0, 127));
      load(d, 2, 64);
      sweep();
    end

    // Asynchronous reset in the middle of a load.
    reload_pulse();
    for (int k = 0; k < 64; k++) d[k] = int'($urandom_range(1, 127));
    load(d, 0, 20);
    W = 3'd0;
    J = 3'd1;
    InValid = 1'b1;
    InCost  = d[20][6:0];
    #2;
    RST_N = 1'b0;
    #1;
    clear_model();
    chk("async_reset_cost", int'(Cost), 0);
    chk("async_reset_tableready", int'(TableReady), 0);
    chk("async_reset_inready", int'(InReady), 1);
    chk("async_reset_lower_bound", int'(LowerBound), 0);
    InValid = 1'b0;
    step();
    RST_N = 1'b1;
    step();
    sweep();
    for (int k = 0; k < 64; k++) d[k] = int'($urandom_range(0, 127));
    load(d, 0, 64);
    sweep();

    repeat (2) step();
    chk("cost_q_drained", cost_q.size(), 0);
    chk("lb_q_drained", lb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Upstream cost store for the job-assignment (JAM) engine. It accepts an 8×8 worker/job cost matrix over a valid/ready stream and holds it in a register file. It serves the engine's `W`/`J` lookups combinationally on `Cost` in the same cycle, and raises `TableReady` to release the engine once the matrix is complete. While loading, it also computes the assignment lower bound: the sum of the eight row minima.

## Interface
Parameters:
- `N_SIDE`, default 8: workers and jobs per side. Fixed at 8; the index width is 3.
- `COST_W`, default 7: bit width of each cost entry.

Ports:
- `CLK`, input, 1: single clock, rising edge.
- `RST_N`, input, 1: reset, asynchronous and active-low.
- `InValid`, input, 1: `InCost` holds a beat.
- `InReady`, output, 1: block accepts a beat this cycle.
- `InCost`, input, 7: cost entry. Entries arrive in row-major order, entry k = (worker k/8, job k%8).
- `Reload`, input, 1: one-cycle pulse that restarts loading from entry 0.
- `W`, input, 3: worker index, driven by the engine.
- `J`, input, 3: job index, driven by the engine.
- `Cost`, output, 7: entry at (`W`,`J`), combinational.
- `TableReady`, output, 1: all 64 entries are loaded; the engine may run.
- `LowerBound`, output, 10: sum of the eight row minima. Valid while `TableReady`=1.

## Operation
- States: `LOAD` and `DONE`. Reset enters `LOAD`.
- `InReady` = (state==`LOAD`) && !`Reload`.
- A beat is accepted when `InValid` && `InReady`. The accepted beat is written to `mem[idx]`, and `idx` (6-bit) increments.
- Row-minimum tracking:
  - `row_min` loads `InCost` on accept with idx[2:0]==0.
  - Otherwise, on accept, `row_min` takes min(`row_min`, `InCost`).
- On accept with idx[2:0]==7, `lb_acc` (10-bit) += min(`row_min`, `InCost`). The maximum is 8×127 = 1016, so there is no overflow.
- On accept with idx==63:
  - state goes to `DONE`
  - `idx` wraps to 0
  - `TableReady` is set
- In `DONE`, further `InValid` beats are not accepted because `InReady`=0.
- `Reload` in either state:
  - state goes to `LOAD`, `idx`=0, `lb_acc`=0, `row_min`=0
  - `TableReady` is cleared
  - `mem` is kept and is overwritten by the new load
- `Reload` together with `InValid`: `Reload` wins and the beat is not accepted, since `InReady`=0 that cycle.
- `Cost` = `mem[{W,J}]` in every state. A read of an entry written in the same cycle returns the old value.
- `LowerBound` = `lb_acc`. Bench and engine ignore it when `TableReady`=0.

## Timing
- Reset values:
  - state `LOAD`; `idx`=0; `row_min`=0; `lb_acc`=0; all 64 `mem` entries = 0
  - `InReady`=1; `TableReady`=0; `LowerBound`=0; `Cost`=0
- Reset mid-load takes effect immediately and asynchronously. Partial data is discarded, and reload starts from entry 0 after `RST_N` deasserts.
- Load latency: with `InValid` held high, 64 beats are accepted in 64 consecutive cycles. `TableReady` rises at the edge that accepts beat 63 and is visible in the next cycle. `LowerBound` is final in that same cycle.
- Stalls (`InValid`=0) leave `idx`, `row_min` and `lb_acc` unchanged.
- `Cost` has zero-cycle latency. The engine presents `W`/`J` from registers and samples `Cost` on the same edge.
- `TableReady` falls in the cycle after a `Reload` pulse.

## Structure
- Shared package `jam_pkg` holds:
  - `N_SIDE`, `COST_W`, `IDX_W`=3
  - `SUM_W`=10, shared with the engine's `MinCost`
  - the `cost_state_e` enum {`LOAD`, `DONE`}
- Sub-module `jam_cost_rf`: a 64×7 register file with one write port (addr, data, we) and one asynchronous read port, with async active-low reset to 0.
- The top level holds the FSM, `idx`, `row_min` and `lb_acc`.

## Test plan
- Reset, then 64 back-to-back beats with `InCost`=k%128 (k=0..63). Required:
  - `TableReady`=1 in cycle 65
  - `LowerBound` = 0+8+16+…+56 = 224
  - sweeping all `W`,`J` returns 8W+J
- Same data with `InValid` toggling every other cycle. Required: identical contents and `LowerBound`=224; `TableReady` rises after 128 cycles.
- All entries 127 except the diagonal = 1. Required: `LowerBound`=8; (3,3) reads 1; (3,4) reads 127.
- `Reload` pulsed at beat 30 while `InValid` is high. Required:
  - that beat is not accepted; `idx` returns to 0
  - a new 64-beat load of constant 5 gives `LowerBound`=40 and every `Cost`=5
- In `DONE`, hold `InValid`=1 for 10 cycles. Required: `InReady`=0, contents unchanged, `TableReady` stays 1.
- Assert `RST_N`=0 mid-load at beat 20. Required: `Cost`=0 for all addresses, `TableReady`=0, `InReady`=1; a full reload then completes normally.
